// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM subsystem (sdram_controller and
// sdram_arbiter): default bus widths and the arbiter's state encoding.
// ---------------------------------------------------------------------------
package sdram_pkg;

    // Default controller bus widths, shared by the controller and the arbiter
    localparam int SDRAM_ADDR_W = 24;
    localparam int SDRAM_DATA_W = 16;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        DONE    = 2'd2,
        REFRESH = 2'd3
    } arbState_e;

endpackage

// File: rtl/sdram_refresh_timer.sv
// ---------------------------------------------------------------------------
// sdram_refresh_timer
// Free-running refresh interval counter with a sticky "refresh pending" flag
// and a one-cycle overrun pulse.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-low reset
//   clear_i    clears the pending flag (driven when the arbiter starts a refresh)
//   pending_o  a refresh interval has elapsed and no refresh has started yet
//   overrun_o  one-cycle pulse: an interval elapsed while one was still pending
// ---------------------------------------------------------------------------
module sdram_refresh_timer #(
    parameter int REFRESH_INTERVAL = 780
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic pending_o,
    output logic overrun_o
);

    localparam int CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             wrap;

    assign wrap = (count_q == CNT_W'(REFRESH_INTERVAL - 1));

    // Next-state logic. A wrap always (re)arms the pending flag, so a wrap
    // landing on the same edge as a clear queues the next refresh instead of
    // losing it; only a wrap onto an un-serviced request counts as overrun.
    always_comb begin
        count_d   = wrap ? '0 : count_q + 1'b1;
        overrun_d = wrap && pending_q && !clear_i;
        pending_d = pending_q;
        if (wrap) begin
            pending_d = 1'b1;
        end else if (clear_i) begin
            pending_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q   <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending_o = pending_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
// Shares one SDRAM controller between port 0 (CPU) and port 1 (display/DMA),
// inserting periodic auto-refresh ahead of both requesters.
//
// Build option: define SDRAM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise port 0 always wins.
//
// Ports:
//   clk, reset                   clock / synchronous active-low reset
//   req0/1, we0/1, addr0/1,      requester side: req held until ack,
//   wdata0/1                     command fields stable while req is high
//   ack0/1                       one-cycle completion pulse
//   rdata                        read data, valid in the ack cycle of a read
//   mem_req                      one-cycle start strobe to the controller
//   mem_we/addr/wdata            command held for the whole access
//   mem_rdata                    controller read data
//   mem_refresh                  refresh command, held REFRESH_CYCLES
//   busy                         high whenever the arbiter is not idle
//   refresh_overrun              pulse when a refresh interval is missed
// ---------------------------------------------------------------------------
module sdram_arbiter import sdram_pkg::*; #(
    parameter int ADDR_W           = SDRAM_ADDR_W,
    parameter int DATA_W           = SDRAM_DATA_W,
    parameter int ACCESS_CYCLES    = 3,
    parameter int REFRESH_INTERVAL = 780,
    parameter int REFRESH_CYCLES   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_refresh,
    output logic              busy,
    output logic              refresh_overrun
);

    // One step counter times both the access window and the refresh window
    localparam int STEP_MAX = (ACCESS_CYCLES > REFRESH_CYCLES) ? ACCESS_CYCLES : REFRESH_CYCLES;
    localparam int STEP_W   = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;

    arbState_e         state_q;
    logic [STEP_W-1:0] step_q;
    logic              grant_q;
    logic              ack0_q, ack1_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_req_q, mem_we_q, mem_refresh_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic refreshPending;
    logic refreshClear;
    logic pickPort;

    // A refresh starts (and its pending flag clears) on the idle edge that sees it
    assign refreshClear = (state_q == IDLE) && refreshPending;

    sdram_refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (refreshClear),
        .pending_o(refreshPending),
        .overrun_o(refresh_overrun)
    );

`ifdef SDRAM_ARB_RR_EN
    logic lastGrant_q;
    logic grantNow;

    // On a tie, serve the port that was not granted last time
    assign pickPort = (req0 && req1) ? ~lastGrant_q : ~req0;
    assign grantNow = (state_q == IDLE) && !refreshPending && (req0 || req1);

    // Round-robin pointer follows every grant; starts at 1 so port 0 wins
    // the first tie after reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            lastGrant_q <= 1'b1;
        end else if (grantNow) begin
            lastGrant_q <= pickPort;
        end
    end
`else
    // Fixed priority: port 1 only when port 0 is not asking
    assign pickPort = ~req0;
`endif

    // Sequencer. All controller-facing signals and acks are registered here.
    // The pending refresh is checked before requests, so refresh is taken at
    // the first idle edge after it becomes visible but never interrupts an
    // access. DONE always returns through IDLE, so a held req is never
    // granted twice from one ack.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            step_q        <= '0;
            grant_q       <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            rdata_q       <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_refresh_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (refreshPending) begin
                        state_q       <= REFRESH;
                        step_q        <= '0;
                        mem_refresh_q <= 1'b1;
                    end else if (req0 || req1) begin
                        state_q     <= ACCESS;
                        step_q      <= '0;
                        grant_q     <= pickPort;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= pickPort ? we1    : we0;
                        mem_addr_q  <= pickPort ? addr1  : addr0;
                        mem_wdata_q <= pickPort ? wdata1 : wdata0;
                    end
                end
                ACCESS: begin
                    mem_req_q <= 1'b0;
                    if (step_q == STEP_W'(ACCESS_CYCLES - 1)) begin
                        if (!mem_we_q) begin
                            rdata_q <= mem_rdata;
                        end
                        state_q     <= DONE;
                        ack0_q      <= ~grant_q;
                        ack1_q      <= grant_q;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                DONE: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    state_q <= IDLE;
                end
                REFRESH: begin
                    if (step_q == STEP_W'(REFRESH_CYCLES - 1)) begin
                        mem_refresh_q <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign rdata       = rdata_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_refresh = mem_refresh_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbiter
// Bench for sdram_arbiter. The main instance uses default parameters and is
// checked every cycle against a transaction-timeline reference model. A
// second instance (ACCESS_CYCLES=12, REFRESH_INTERVAL=10) exercises the
// refresh overrun case with directed expectations.
// ---------------------------------------------------------------------------
module tb_sdram_arbiter;

    localparam int AW   = 24;
    localparam int DW   = 16;
    localparam int AC   = 3;
    localparam int RI   = 780;
    localparam int RC   = 8;
    localparam int B_AC = 12;
    localparam int B_RI = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0, mem_rdata = '0;
    logic          ack0, ack1, mem_req, mem_we, mem_refresh, busy, refresh_overrun;
    logic [DW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    logic          rstB = 1'b0;
    logic          reqB0 = 1'b0, reqB1 = 1'b0, weB0 = 1'b0, weB1 = 1'b0;
    logic [AW-1:0] addrB0 = '0, addrB1 = '0;
    logic [DW-1:0] wdataB0 = '0, wdataB1 = '0, memRdataB = '0;
    logic          ackB0, ackB1, memReqB, memWeB, memRefreshB, busyB, overrunB;
    logic [DW-1:0] rdataB, memWdataB;
    logic [AW-1:0] memAddrB;

    int vectors = 0;
    int errors  = 0;

    // Clock generation
    always #5 clk = ~clk;

    sdram_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_refresh(mem_refresh), .busy(busy),
        .refresh_overrun(refresh_overrun)
    );

    sdram_arbiter #(.ACCESS_CYCLES(B_AC), .REFRESH_INTERVAL(B_RI)) dutB (
        .clk(clk), .reset(rstB),
        .req0(reqB0), .req1(reqB1), .we0(weB0), .we1(weB1),
        .addr0(addrB0), .addr1(addrB1), .wdata0(wdataB0), .wdata1(wdataB1),
        .ack0(ackB0), .ack1(ackB1), .rdata(rdataB),
        .mem_req(memReqB), .mem_we(memWeB), .mem_addr(memAddrB), .mem_wdata(memWdataB),
        .mem_rdata(memRdataB), .mem_refresh(memRefreshB), .busy(busyB),
        .refresh_overrun(overrunB)
    );

    // Observed outputs of the main instance, packed in the same order as expVec:
    // [62] ack0 [61] ack1 [60:45] rdata [44] mem_req [43] mem_we
    // [42:19] mem_addr [18:3] mem_wdata [2] mem_refresh [1] busy [0] overrun
    logic [62:0] obsVec;
    assign obsVec = {ack0, ack1, rdata, mem_req, mem_we, mem_addr, mem_wdata,
                     mem_refresh, busy, refresh_overrun};

    // Reference model state: the current operation is described by its kind
    // (0 none, 1 access, 2 refresh) and the edge number it was granted on;
    // every output follows from the distance to that edge.
    int          n = 0;
    int          opKind = 0, opStart = 0, opPort = 0;
    logic        opWe = 1'b0;
    logic [AW-1:0] opAddr = '0;
    logic [DW-1:0] opWdata = '0, mRdata = '0;
    logic        mPending = 1'b0;
    logic        lastGrant = 1'b1;
    logic [62:0] expVec = '0;
    int          cool0 = 0, cool1 = 0;

    task automatic modelEdge();
        bit wrap, free, clearNow;
        int d, port;
        logic e0, e1, eReq, eWe, eRef, eBusy, eOv;
        logic [AW-1:0] eAddr;
        logic [DW-1:0] eWd;
        if (!reset) begin
            n = 0; mPending = 1'b0; opKind = 0; opStart = 0;
            mRdata = '0; lastGrant = 1'b1; expVec = '0;
        end else begin
            n++;
            // counter reads 0 after reset, so the interval elapses every RI edges
            wrap = (n % RI) == 0;
            if (opKind == 1 && n == opStart + AC && !opWe) mRdata = mem_rdata;
            free = (opKind == 0) || (opKind == 1 && n >= opStart + AC + 2) ||
                   (opKind == 2 && n >= opStart + RC + 1);
            clearNow = 1'b0;
            if (free) begin
                opKind = 0;
                if (mPending) begin
                    opKind = 2; opStart = n; clearNow = 1'b1;
                end else if (req0 || req1) begin
`ifdef SDRAM_ARB_RR_EN
                    if (req0 && req1) port = lastGrant ? 0 : 1;
                    else port = req0 ? 0 : 1;
`else
                    port = req0 ? 0 : 1;
`endif
                    lastGrant = (port == 1);
                    opKind = 1; opStart = n; opPort = port;
                    opWe    = (port == 1) ? we1 : we0;
                    opAddr  = (port == 1) ? addr1 : addr0;
                    opWdata = (port == 1) ? wdata1 : wdata0;
                end
            end
            eOv = wrap && mPending && !clearNow;
            if (wrap) mPending = 1'b1;
            else if (clearNow) mPending = 1'b0;
            d = n - opStart;
            e0 = 0; e1 = 0; eReq = 0; eWe = 0; eRef = 0; eBusy = 0;
            eAddr = '0; eWd = '0;
            if (opKind == 1) begin
                eReq  = (d == 0);
                eBusy = (d <= AC);
                if (d < AC) begin eWe = opWe; eAddr = opAddr; eWd = opWdata; end
                if (d == AC) begin e0 = (opPort == 0); e1 = (opPort == 1); end
            end
            if (opKind == 2) begin
                eRef  = (d < RC);
                eBusy = (d < RC);
            end
            expVec = {e0, e1, mRdata, eReq, eWe, eAddr, eWd, eRef, eBusy, eOv};
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            modelEdge();
        end
    end

    // Random requester behaviour: drop req the cycle ack is seen, wait
    // coolLen cycles, then re-request with probability pct.
    task automatic stepPorts(input int pct0, input int pct1, input int coolLen);
        if (expVec[62]) begin
            req0 = 1'b0; cool0 = coolLen;
        end else if (!req0) begin
            if (cool0 > 0) cool0--;
            else if (int'($urandom_range(99)) < pct0) begin
                req0 = 1'b1; we0 = 1'($urandom_range(1));
                addr0 = 24'($urandom); wdata0 = 16'($urandom);
            end
        end
        if (expVec[61]) begin
            req1 = 1'b0; cool1 = coolLen;
        end else if (!req1) begin
            if (cool1 > 0) cool1--;
            else if (int'($urandom_range(99)) < pct1) begin
                req1 = 1'b1; we1 = 1'($urandom_range(1));
                addr1 = 24'($urandom); wdata1 = 16'($urandom);
            end
        end
        mem_rdata = 16'($urandom);
    endtask

    // Let outstanding requests and any pending refresh finish
    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            stepPorts(0, 0, 1);
            if (!req0 && !req1 && !expVec[1] && !mPending) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (obsVec !== 63'd0) begin
                errors++;
                $display("[TB] FAIL reset cyc=%0d got=%h want=0", i, obsVec);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_single_write();
        logic [2:0] want;
        req0 = 1'b1; we0 = 1'b1; addr0 = 24'h001234; wdata0 = 16'hBEEF;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            vectors++;
            if (obsVec !== expVec) begin
                errors++;
                $display("[TB] FAIL write_model cyc=%0d got=%h want=%h", k, obsVec, expVec);
            end
            want = {1'(k == 1), 1'(k == 4), 1'(k <= 4)};
            vectors++;
            if ({mem_req, ack0, busy} !== want) begin
                errors++;
                $display("[TB] FAIL write_timing cyc=%0d got req/ack/busy=%b want=%b",
                         k, {mem_req, ack0, busy}, want);
            end
            if (k <= 3) begin
                vectors++;
                if ({mem_we, mem_addr} !== {1'b1, 24'h001234}) begin
                    errors++;
                    $display("[TB] FAIL write_cmd cyc=%0d got we=%b addr=%h want we=1 addr=001234",
                             k, mem_we, mem_addr);
                end
            end
            if (k == 4) req0 = 1'b0;
        end
    endtask

    task automatic test_single_read();
        req1 = 1'b1; we1 = 1'b0; addr1 = 24'h000010; mem_rdata = 16'hA5A5;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            vectors++;
            if (obsVec !== expVec) begin
                errors++;
                $display("[TB] FAIL read_model cyc=%0d got=%h want=%h", k, obsVec, expVec);
            end
            vectors++;
            if ({ack0, ack1} !== {1'b0, 1'(k == 4)}) begin
                errors++;
                $display("[TB] FAIL read_ack cyc=%0d got=%b want=%b", k, {ack0, ack1}, {1'b0, 1'(k == 4)});
            end
            if (k == 4) begin
                vectors++;
                if (rdata !== 16'hA5A5) begin
                    errors++;
                    $display("[TB] FAIL read_data got=%h want=a5a5", rdata);
                end
                req1 = 1'b0;
            end
        end
    endtask

    task automatic test_contention();
        bit ok;
        req0 = 1'b1; we0 = 1'b0; addr0 = 24'h000100;
        req1 = 1'b1; we1 = 1'b1; addr1 = 24'h000200; wdata1 = 16'h0F0F;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            vectors++;
            if (obsVec !== expVec) begin
                errors++;
                $display("[TB] FAIL contention_model cyc=%0d got=%h want=%h", k, obsVec, expVec);
            end
            if (k <= 9) begin
                vectors++;
                if ({ack0, ack1} !== {1'(k == 4), 1'(k == 9)}) begin
                    errors++;
                    $display("[TB] FAIL contention_order cyc=%0d got=%b want=%b",
                             k, {ack0, ack1}, {1'(k == 4), 1'(k == 9)});
                end
            end
            stepPorts(100, 100, 1);
        end
        drain(ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL contention_drain got=timeout want=idle");
        end
    endtask

    task automatic test_reset_mid_access();
        req0 = 1'b1; we0 = 1'b1; addr0 = 24'h00ABCD; wdata0 = 16'h1357;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            vectors++;
            if (obsVec !== expVec) begin
                errors++;
                $display("[TB] FAIL midreset_model cyc=%0d got=%h want=%h", k, obsVec, expVec);
            end
            vectors++;
            if (ack0 !== 1'(k == 7)) begin
                errors++;
                $display("[TB] FAIL midreset_ack cyc=%0d got=%b want=%b", k, ack0, 1'(k == 7));
            end
            if (k == 3) begin
                vectors++;
                if (obsVec !== 63'd0) begin
                    errors++;
                    $display("[TB] FAIL midreset_clear got=%h want=0", obsVec);
                end
            end
            if (k == 2) reset = 1'b0;
            if (k == 3) reset = 1'b1;
            if (k == 7) req0 = 1'b0;
        end
    endtask

    task automatic test_refresh_priority();
        int refCycles = 0;
        bit ok;
        for (int i = 0; i < 1200 && n < RI + 20; i++) begin
            @(negedge clk);
            vectors++;
            if (obsVec !== expVec) begin
                errors++;
                $display("[TB] FAIL refresh_model n=%0d got=%h want=%h", n, obsVec, expVec);
            end
            vectors++;
            if (mem_refresh && mem_req) begin
                errors++;
                $display("[TB] FAIL refresh_exclusive n=%0d got req=1 refresh=1 want not both", n);
            end
            if (mem_refresh) refCycles++;
            stepPorts(100, 0, 0);
        end
        vectors++;
        if (refCycles != RC) begin
            errors++;
            $display("[TB] FAIL refresh_length got=%0d want=%0d", refCycles, RC);
        end
        drain(ok);
        vectors++;
        if (!ok || n < RI + 20) begin
            errors++;
            $display("[TB] FAIL refresh_progress got n=%0d drained=%0d want n>=%0d drained=1", n, ok, RI + 20);
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int seg = 0; seg < 5; seg++) begin
            int p0 = 20 + 15 * seg;
            int p1 = 90 - 15 * seg;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                vectors++;
                if (obsVec !== expVec) begin
                    errors++;
                    $display("[TB] FAIL random_model n=%0d got=%h want=%h", n, obsVec, expVec);
                end
                stepPorts(p0, p1, int'($urandom_range(2)));
            end
        end
        drain(ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL random_drain got=timeout want=idle");
        end
    endtask

    // Access of 12 cycles granted at edge 9 spans interval wraps at edges 10
    // and 20: the second wrap overruns, the refresh runs after the ack.
    task automatic test_overrun();
        logic [5:0] want;
        int ovCount = 0, refCount = 0;
        rstB = 1'b0;
        @(negedge clk);
        rstB = 1'b1; weB0 = 1'b1; addrB0 = 24'h0000AA; wdataB0 = 16'h00AA;
        for (int e = 1; e <= 31; e++) begin
            reqB0 = (e >= 9 && e <= 21);
            @(negedge clk);
            want = {1'(e == 21), 1'b0, 1'(e == 9), 1'(e >= 23 && e <= 30), 1'(e == 20),
                    1'((e >= 9 && e <= 21) || (e >= 23 && e <= 30))};
            vectors++;
            if ({ackB0, ackB1, memReqB, memRefreshB, overrunB, busyB} !== want) begin
                errors++;
                $display("[TB] FAIL overrun_timing edge=%0d got=%b want=%b", e,
                         {ackB0, ackB1, memReqB, memRefreshB, overrunB, busyB}, want);
            end
            if (overrunB) ovCount++;
            if (memRefreshB) refCount++;
        end
        vectors++;
        if (ovCount != 1 || refCount != RC) begin
            errors++;
            $display("[TB] FAIL overrun_count got ov=%0d ref=%0d want ov=1 ref=%0d", ovCount, refCount, RC);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_reset_mid_access();
        test_refresh_priority();
        test_random();
        test_overrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Hard stop in case something stalls the sequence
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
